// File: rtl/serial_link_perf_pkg.sv
// +----------------------------------------------------------------------------+
// | serial_link_perf_pkg: shared types and constants for the link perf window. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package serial_link_perf_pkg;

  typedef enum logic [1:0] {
    PERF_IDLE = 2'd0,
    PERF_RUN  = 2'd1,
    PERF_DONE = 2'd2
  } perf_state_e;

  localparam int PerfAddrCycles = 0;
  localparam int PerfAddrEvBase = 1;

  localparam int PerfStatusBusyBit = 0;
  localparam int PerfStatusDoneBit = 1;
  localparam int PerfStatusOvfBit  = 2;

endpackage

`default_nettype wire

// File: rtl/serial_link_perf_counter.sv
// +----------------------------------------------------------------------------+
// | serial_link_perf_counter: one event counter with clear/enable/increment.   |
// | SERIAL_LINK_PERF_SATURATE_EN makes it saturate; otherwise it wraps.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module serial_link_perf_counter
  import serial_link_perf_pkg::*;
#(
  parameter int CntWidth = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_clr,
  input  logic                i_en,
  input  logic                i_inc,
  output logic [CntWidth-1:0] o_nxt,
  output logic                o_sat
);

  logic [CntWidth-1:0] r_cnt;
  logic [CntWidth-1:0] w_nxt;
  logic                w_sat;

  // o_nxt exposes the post-edge value so the snapshot can include the final cycle.
  always_comb begin
    w_nxt = r_cnt;
    w_sat = 1'b0;
    if (i_clr) begin
      w_nxt = '0;
    end else if (i_en && i_inc) begin
`ifdef SERIAL_LINK_PERF_SATURATE_EN
      if (&r_cnt) begin
        w_sat = 1'b1;
      end else begin
        w_nxt = r_cnt + CntWidth'(1);
      end
`else
      w_nxt = r_cnt + CntWidth'(1);
`endif
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_nxt;
    end
  end

  assign o_nxt = w_nxt;
  assign o_sat = w_sat;

endmodule

`default_nettype wire

// File: rtl/serial_link_perf_window.sv
// +----------------------------------------------------------------------------+
// | serial_link_perf_window: windowed event monitor with snapshot read port.   |
// | Optional saturation/overflow via SERIAL_LINK_PERF_SATURATE_EN.             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module serial_link_perf_window
  import serial_link_perf_pkg::*;
#(
  parameter int NumEvents = 6,
  parameter int CntWidth  = 32,
  parameter int AddrWidth = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 clear_i,
  input  logic [CntWidth-1:0]  window_i,
  input  logic [NumEvents-1:0] event_i,
  output logic                 busy_o,
  output logic                 done_o,
  input  logic                 rd_req_valid_i,
  output logic                 rd_req_ready_o,
  input  logic [AddrWidth-1:0] rd_addr_i,
  output logic                 rd_rsp_valid_o,
  input  logic                 rd_rsp_ready_i,
  output logic [CntWidth-1:0]  rd_rsp_data_o,
  output logic                 rd_rsp_err_o
);

  localparam int c_NumCnt     = NumEvents + 1;
  localparam int c_AddrStatus = NumEvents + 1;

  perf_state_e         r_state;
  perf_state_e         w_state_nxt;
  logic [CntWidth-1:0] r_win;
  logic [CntWidth-1:0] r_snap     [c_NumCnt];
  logic [CntWidth-1:0] w_snap_nxt [c_NumCnt];
  logic [CntWidth-1:0] w_live_nxt [c_NumCnt];
  logic [c_NumCnt-1:0] w_inc;
  logic [c_NumCnt-1:0] w_sat;
  logic                r_ovf;
  logic                w_ovf_nxt;
  logic                w_run;
  logic                w_start_ok;
  logic                w_live_clr;
  logic                w_term;
  logic [2:0]          w_status;
  logic [CntWidth-1:0] w_rd_data;
  logic                w_rd_err;
  logic                r_rsp_valid;
  logic                r_rsp_err;
  logic [CntWidth-1:0] r_rsp_data;

  assign w_run      = (r_state == PERF_RUN);
  assign w_start_ok = start_i && !w_run;
  assign w_live_clr = clear_i || w_start_ok;
  assign w_term     = w_run && !clear_i &&
                      (stop_i || ((r_win != '0) && (w_live_nxt[PerfAddrCycles] == r_win)));

  always_comb begin
    w_inc = '0;
    w_inc[PerfAddrCycles] = 1'b1;
    for (int i = 0; i < NumEvents; i++) begin
      w_inc[PerfAddrEvBase + i] = event_i[i];
    end
  end

  generate
    for (genvar g = 0; g < c_NumCnt; g++) begin : g_cnt
      serial_link_perf_counter #(
        .CntWidth(CntWidth)
      ) u_cnt (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_clr (w_live_clr),
        .i_en  (w_run),
        .i_inc (w_inc[g]),
        .o_nxt (w_live_nxt[g]),
        .o_sat (w_sat[g])
      );
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    if (clear_i) begin
      w_state_nxt = PERF_IDLE;
    end else begin
      case (r_state)
        PERF_IDLE, PERF_DONE: if (start_i) w_state_nxt = PERF_RUN;
        PERF_RUN:             if (w_term)  w_state_nxt = PERF_DONE;
        default:              w_state_nxt = PERF_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= PERF_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state views let a read issued on the update edge return the new value.
  always_comb begin
    for (int k = 0; k < c_NumCnt; k++) begin
      w_snap_nxt[k] = clear_i ? '0 : (w_term ? w_live_nxt[k] : r_snap[k]);
    end
  end

  assign w_ovf_nxt = w_live_clr ? 1'b0 : (r_ovf || (|w_sat));

  always_comb begin
    w_status = '0;
    w_status[PerfStatusBusyBit] = (w_state_nxt == PERF_RUN);
    w_status[PerfStatusDoneBit] = (w_state_nxt == PERF_DONE);
    w_status[PerfStatusOvfBit]  = w_ovf_nxt;
  end

  always_comb begin
    w_rd_data = '0;
    w_rd_err  = 1'b1;
    for (int k = 0; k < c_NumCnt; k++) begin
      if (rd_addr_i == AddrWidth'(k)) begin
        w_rd_data = w_snap_nxt[k];
        w_rd_err  = 1'b0;
      end
    end
    if (rd_addr_i == AddrWidth'(c_AddrStatus)) begin
      w_rd_data = CntWidth'(w_status);
      w_rd_err  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_win <= '0;
      r_ovf <= 1'b0;
      for (int k = 0; k < c_NumCnt; k++) begin
        r_snap[k] <= '0;
      end
    end else begin
      r_ovf <= w_ovf_nxt;
      if (w_start_ok && !clear_i) begin
        r_win <= window_i;
      end
      for (int k = 0; k < c_NumCnt; k++) begin
        r_snap[k] <= w_snap_nxt[k];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else if (rd_req_valid_i && !r_rsp_valid) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_rd_data;
      r_rsp_err   <= w_rd_err;
    end else if (r_rsp_valid && rd_rsp_ready_i) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign busy_o         = w_run;
  assign done_o         = (r_state == PERF_DONE);
  assign rd_req_ready_o = !r_rsp_valid;
  assign rd_rsp_valid_o = r_rsp_valid;
  assign rd_rsp_data_o  = r_rsp_data;
  assign rd_rsp_err_o   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_serial_link_perf_window.sv
// +----------------------------------------------------------------------------+
// | tb_serial_link_perf_window: scoreboard bench for a 32-bit and 4-bit DUT.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_serial_link_perf_window;

  localparam int NE = 6;
  localparam int AW = 4;
`ifdef SERIAL_LINK_PERF_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_DONE = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, stop, clear, req_valid, rsp_ready;
  logic [31:0]   window;
  logic [NE-1:0] ev;
  logic [AW-1:0] addr;

  logic        busy0, done0, rqr0, rv0, err0;
  logic [31:0] rd0;
  logic        busy1, done1, rqr1, rv1, err1;
  logic [3:0]  rd1;

  serial_link_perf_window #(.NumEvents(NE), .CntWidth(32), .AddrWidth(AW)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .clear_i(clear),
    .window_i(window), .event_i(ev), .busy_o(busy0), .done_o(done0),
    .rd_req_valid_i(req_valid), .rd_req_ready_o(rqr0), .rd_addr_i(addr),
    .rd_rsp_valid_o(rv0), .rd_rsp_ready_i(rsp_ready), .rd_rsp_data_o(rd0),
    .rd_rsp_err_o(err0)
  );

  serial_link_perf_window #(.NumEvents(NE), .CntWidth(4), .AddrWidth(AW)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .clear_i(clear),
    .window_i(4'd0), .event_i(ev), .busy_o(busy1), .done_o(done1),
    .rd_req_valid_i(req_valid), .rd_req_ready_o(rqr1), .rd_addr_i(addr),
    .rd_rsp_valid_o(rv1), .rd_rsp_ready_i(rsp_ready), .rd_rsp_data_o(rd1),
    .rd_rsp_err_o(err1)
  );

  always #5 clk = ~clk;

  // Reference model: exact (unbounded) counts, reduced to the DUT width on read.
  int     st   [2];
  longint cyc  [2];
  longint evc  [2][NE];
  longint scyc [2];
  longint sev  [2][NE];
  longint win  [2];
  bit     mrv;
  int     ev_mode;

  typedef struct {
    longint d;
    bit     e;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input longint exp);
    tests++;
    if (act !== 64'(exp)) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint fold(input int k, input longint x);
    if (k == 0) return x & 64'hFFFF_FFFF;
    if (SAT) return (x > 15) ? 64'd15 : x;
    return x % 16;
  endfunction

  function automatic exp_t expect_rd(input int k, input int a);
    exp_t r;
    r.d = 0;
    r.e = 1'b0;
    if (a == 0) r.d = fold(k, scyc[k]);
    else if (a <= NE) r.d = fold(k, sev[k][a-1]);
    else if (a == NE + 1)
      r.d = ((SAT && k == 1 && cyc[k] > 15) ? 4 : 0) +
            ((st[k] == S_DONE) ? 2 : 0) + ((st[k] == S_RUN) ? 1 : 0);
    else r.e = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      st[k] = S_IDLE; cyc[k] = 0; scyc[k] = 0; win[k] = 0;
      for (int i = 0; i < NE; i++) begin evc[k][i] = 0; sev[k][i] = 0; end
    end
    mrv = 1'b0;
    q0.delete();
    q1.delete();
  endtask

  task automatic model_step();
    if (rst) return;
    for (int k = 0; k < 2; k++) begin
      if (clear) begin
        st[k] = S_IDLE; cyc[k] = 0; scyc[k] = 0;
        for (int i = 0; i < NE; i++) begin evc[k][i] = 0; sev[k][i] = 0; end
      end else if (st[k] != S_RUN) begin
        if (start) begin
          st[k] = S_RUN; cyc[k] = 0;
          for (int i = 0; i < NE; i++) evc[k][i] = 0;
          win[k] = (k == 0) ? longint'(window) : 0;
        end
      end else begin
        cyc[k]++;
        for (int i = 0; i < NE; i++) evc[k][i] += ev[i];
        if (stop || (win[k] != 0 && cyc[k] == win[k])) begin
          scyc[k] = cyc[k];
          for (int i = 0; i < NE; i++) sev[k][i] = evc[k][i];
          st[k] = S_DONE;
        end
      end
    end
    if (mrv) begin
      if (rsp_ready) mrv = 1'b0;
    end else if (req_valid) begin
      mrv = 1'b1;
      q0.push_back(expect_rd(0, int'(addr)));
      q1.push_back(expect_rd(1, int'(addr)));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (ev_mode == 1) begin
      ev[0] = 1'b1;
      ev[1] = ~ev[1];
      ev[NE-1:2] = ($urandom & ((1 << (NE-2)) - 1));
    end else begin
      ev = NE'($urandom);
    end
  endtask

  task automatic do_read(input int a, input int hold);
    int n;
    n = 0;
    while (mrv && n < 50) begin rsp_ready = 1'b1; tick(); n++; end
    req_valid = 1'b1; addr = AW'(a); rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < hold; i++) tick();
    rsp_ready = 1'b1;
    tick();
  endtask

  task automatic run_until_done0(input int limit);
    int n;
    n = 0;
    while (st[0] != S_DONE && n < limit) begin tick(); n++; end
  endtask

  // Monitor: compares every cycle and pops a response when it is accepted.
  always @(negedge clk) begin
    chk("busy0", busy0, st[0] == S_RUN);
    chk("done0", done0, st[0] == S_DONE);
    chk("busy1", busy1, st[1] == S_RUN);
    chk("done1", done1, st[1] == S_DONE);
    chk("req_ready0", rqr0, !mrv);
    chk("req_ready1", rqr1, !mrv);
    chk("rsp_valid0", rv0, mrv);
    chk("rsp_valid1", rv1, mrv);
    if (rv0 === 1'b1) begin
      if (q0.size() == 0) begin
        tests++; fails++;
        $display("FAIL rsp0_unexpected: got valid expected no response");
      end else begin
        chk("rd_data0", rd0, q0[0].d);
        chk("rd_err0", err0, q0[0].e);
        if (rsp_ready) void'(q0.pop_front());
      end
    end
    if (rv1 === 1'b1) begin
      if (q1.size() == 0) begin
        tests++; fails++;
        $display("FAIL rsp1_unexpected: got valid expected no response");
      end else begin
        chk("rd_data1", rd1, q1[0].d);
        chk("rd_err1", err1, q1[0].e);
        if (rsp_ready) void'(q1.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; window = '0;
    ev = '0; req_valid = 1'b0; addr = '0; rsp_ready = 1'b1; ev_mode = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_data0", rd0, 0);
    chk("rst_err0", err0, 0);

    // 100-cycle window with a tied-high and a toggling strobe
    ev_mode = 1; ev = '0; window = 32'd100;
    start = 1'b1; tick(); start = 1'b0;
    run_until_done0(200);
    ev_mode = 0;
    for (int a = 0; a <= NE + 1; a++) do_read(a, 0);
    do_read(15, 5);

    // Unbounded window ended by stop on the 37th counted cycle
    window = 32'd0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (36) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    do_read(0, 0);
    do_read(NE + 1, 0);

    // 20 cycles with event 0 high: exercises 4-bit wrap or saturation
    ev_mode = 1;
    start = 1'b1; tick(); start = 1'b0;
    repeat (19) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    ev_mode = 0;
    do_read(1, 0);
    do_read(NE + 1, 0);
    do_read(0, 2);

    // clear together with start while DONE
    window = 32'd10;
    start = 1'b1; tick(); start = 1'b0;
    run_until_done0(50);
    clear = 1'b1; start = 1'b1; tick(); clear = 1'b0; start = 1'b0;
    do_read(0, 0);
    do_read(1, 0);
    do_read(NE + 1, 0);

    // Asynchronous reset in the middle of a window
    window = 32'd0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (20) tick();
    #2 rst = 1'b1;
    model_reset();
    tick();
    rst = 1'b0;
    do_read(0, 0);

    // Randomized control, windows, reads and back-pressure
    for (int i = 0; i < 500; i++) begin
      start  = ($urandom % 20) == 0;
      stop   = ($urandom % 25) == 0;
      clear  = ($urandom % 60) == 0;
      window = $urandom_range(0, 40);
      if (!mrv && ($urandom % 3) == 0) begin
        req_valid = 1'b1;
        addr = AW'($urandom % 16);
      end
      rsp_ready = ($urandom % 2) == 0;
      tick();
      start = 1'b0; stop = 1'b0; clear = 1'b0; req_valid = 1'b0;
    end

    rsp_ready = 1'b1;
    repeat (4) tick();
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
